// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the buffered uart front end:
//                CPU/uart register addresses, uart status bit positions
//                and the sequencer state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Register addresses (CPU map and uart register port share numbering)
    localparam logic [3:0] RXDATA = 4'd0;
    localparam logic [3:0] TXDATA = 4'd1;
    localparam logic [3:0] STAT   = 4'd2;
    localparam logic [3:0] INV    = 4'd3;
    localparam logic [3:0] DIVL   = 4'd4;
    localparam logic [3:0] DIVH   = 4'd5;
    localparam logic [3:0] IE     = 4'd6;

    // uart status register bit positions
    localparam int X_INT = 0;   // transmitter finished a frame
    localparam int R_INT = 1;   // receiver holds a byte

    // Sequencer that owns the uart register port
    typedef enum logic [1:0] {
        POLL = 2'd0,
        RX   = 2'd1,
        TX   = 2'd2
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_fifo_if
//  Description : Bus bundle around uart_fifo.
//                CPU side : io_addr, io_wdata, io_write, io_read -> io_rdata,
//                           interrupt
//                uart side: u_addr, u_wdata, u_write, u_read <- u_rdata
//                slave  = the buffered front end itself
//                master = its environment (CPU + uart)
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_fifo_if;
    logic [3:0] io_addr;
    logic [7:0] io_wdata;
    logic       io_write;
    logic       io_read;
    logic [7:0] io_rdata;
    logic       interrupt;
    logic [3:0] u_addr;
    logic [7:0] u_wdata;
    logic       u_write;
    logic       u_read;
    logic [7:0] u_rdata;

    modport slave (
        input  io_addr, io_wdata, io_write, io_read, u_rdata,
        output io_rdata, interrupt, u_addr, u_wdata, u_write, u_read
    );

    modport master (
        output io_addr, io_wdata, io_write, io_read, u_rdata,
        input  io_rdata, interrupt, u_addr, u_wdata, u_write, u_read
    );
endinterface
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : byte_fifo
//  Description : DEPTH-entry byte FIFO with first-word-fall-through head.
//                Ports: clk, reset_n, push/push_data, pop, full, empty, head.
//                A push while full lands only if a pop happens the same
//                cycle; a pop while empty is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    input  wire logic       push,
    input  wire logic [7:0] push_data,
    input  wire logic       pop,
    output logic            full,
    output logic            empty,
    output logic [7:0]      head
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign head      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + (AW+1)'(1);
            else if (w_do_pop && !w_do_push) r_count <= r_count - (AW+1)'(1);
        end
    end

    // Storage needs no reset: entries are only visible between push and pop.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end
endmodule
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_fifo
//  Description : Buffered front end for the uart. Adds TX and RX byte FIFOs
//                between the CPU bus and the uart register port; a sequencer
//                polls uart status, feeds the transmitter and drains the
//                receiver. Registers 3/4/5 are forwarded to the uart.
//                Ports: clk, reset_n (async, active low), bus (slave view of
//                uart_fifo_if: CPU access + uart register port).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo #(
    parameter int DEPTH = 8
) (
    input  wire logic   clk,
    input  wire logic   reset_n,
    uart_fifo_if.slave  bus
);
    import uart_pkg::*;

    seq_state_t r_state;
    logic       r_tx_busy;
    logic       r_tx_ovf;
    logic       r_rx_ovr;
    logic       r_rx_ie;
    logic       r_tx_ie;

    logic       w_fwd;
    logic       w_seq_rx;
    logic       w_seq_tx;
    logic       w_tx_push;
    logic       w_rx_pop;
    logic       w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic [7:0] w_tx_head, w_rx_head;
    logic [7:0] w_status;

    // A CPU strobe to a pass-through register takes the uart port this cycle;
    // the sequencer then neither acts nor samples.
    assign w_fwd = (bus.io_write | bus.io_read) &
                   ((bus.io_addr == INV) | (bus.io_addr == DIVL) | (bus.io_addr == DIVH));

    assign w_seq_rx  = ~w_fwd & (r_state == RX);
    assign w_seq_tx  = ~w_fwd & (r_state == TX);
    assign w_tx_push = bus.io_write & (bus.io_addr == TXDATA);
    assign w_rx_pop  = bus.io_read  & (bus.io_addr == RXDATA);

    byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_tx_push),
        .push_data (bus.io_wdata),
        .pop       (w_seq_tx),
        .full      (w_tx_full),
        .empty     (w_tx_empty),
        .head      (w_tx_head)
    );

    byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_seq_rx),
        .push_data (bus.u_rdata),
        .pop       (w_rx_pop),
        .full      (w_rx_full),
        .empty     (w_rx_empty),
        .head      (w_rx_head)
    );

    assign w_status = {3'b000, r_tx_ovf, r_rx_ovr, w_tx_full, w_tx_empty, ~w_rx_empty};

    assign bus.interrupt = (r_rx_ie & ~w_rx_empty) | (r_tx_ie & w_tx_empty) |
                           r_rx_ovr | r_tx_ovf;

    // uart port: forwarded CPU access wins, otherwise the sequencer drives it
    always_comb begin
        bus.u_addr  = STAT;
        bus.u_wdata = 8'h00;
        bus.u_write = 1'b0;
        bus.u_read  = 1'b0;
        if (w_fwd) begin
            bus.u_addr  = bus.io_addr;
            bus.u_wdata = bus.io_wdata;
            bus.u_write = bus.io_write;
            bus.u_read  = bus.io_read;
        end else if (r_state == RX) begin
            bus.u_addr  = RXDATA;
            bus.u_read  = 1'b1;
        end else if (r_state == TX) begin
            bus.u_addr  = TXDATA;
            bus.u_wdata = w_tx_head;
            bus.u_write = 1'b1;
        end
    end

    always_comb begin
        bus.io_rdata = 8'h00;
        case (bus.io_addr)
            RXDATA:           bus.io_rdata = w_rx_empty ? 8'h00 : w_rx_head;
            STAT:             bus.io_rdata = w_status;
            INV, DIVL, DIVH:  bus.io_rdata = bus.u_rdata;
            IE:               bus.io_rdata = {6'b0, r_rx_ie, r_tx_ie};
            default:          bus.io_rdata = 8'h00;
        endcase
    end

    // Sequencer. In POLL u_rdata carries the uart status register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= POLL;
            r_tx_busy <= 1'b0;
        end else if (!w_fwd) begin
            case (r_state)
                POLL: begin
                    if (bus.u_rdata[X_INT]) r_tx_busy <= 1'b0;
                    if (bus.u_rdata[R_INT])
                        r_state <= RX;
                    else if (!w_tx_empty && (!r_tx_busy || bus.u_rdata[X_INT]))
                        r_state <= TX;
                end
                RX: r_state <= POLL;
                TX: begin
                    r_tx_busy <= 1'b1;
                    r_state   <= POLL;
                end
                default: r_state <= POLL;
            endcase
        end
    end

    // Sticky error flags and interrupt enables. A same-cycle set beats a clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_ovf <= 1'b0;
            r_rx_ovr <= 1'b0;
            r_rx_ie  <= 1'b0;
            r_tx_ie  <= 1'b0;
        end else begin
            if (bus.io_write && bus.io_addr == STAT) begin
                if (bus.io_wdata[4]) r_tx_ovf <= 1'b0;
                if (bus.io_wdata[3]) r_rx_ovr <= 1'b0;
            end
            if (w_tx_push && w_tx_full && !w_seq_tx) r_tx_ovf <= 1'b1;
            if (w_seq_rx && w_rx_full && !w_rx_pop)  r_rx_ovr <= 1'b1;
            if (bus.io_write && bus.io_addr == IE) begin
                r_rx_ie <= bus.io_wdata[1];
                r_tx_ie <= bus.io_wdata[0];
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_fifo
//  Description : Self-checking bench for uart_fifo. A stub uart answers the
//                register port; a queue-based model predicts every output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_fifo;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    uart_fifo_if bus();

    uart_fifo #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Stub uart: status at addr 2, received byte at addr 0, pattern elsewhere
    logic       sx, sr;
    logic [7:0] rxb;
    function automatic logic [7:0] stub(input logic [3:0] a, input logic x,
                                        input logic r, input logic [7:0] d);
        if (a == 4'd2)      return {6'b0, r, x};
        else if (a == 4'd0) return d;
        else                return {4'hA, a};
    endfunction
    assign bus.u_rdata = stub(bus.u_addr, sx, sr, rxb);

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_state;        // 0 poll, 1 receive, 2 transmit
    bit         m_busy, m_txovf, m_rxovr, m_rxie, m_txie;
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [7:0] txlog[$];

    task automatic model_reset();
        m_state = 0; m_busy = 0; m_txovf = 0; m_rxovr = 0; m_rxie = 0; m_txie = 0;
        txq.delete(); rxq.delete();
    endtask

    task automatic step(input logic wr, input logic rd, input logic [3:0] a,
                        input logic [7:0] wd, input logic x, input logic r,
                        input logic [7:0] d);
        logic       fwd, e_uw, e_ur, e_irq, ovr_set;
        logic [3:0] e_ua;
        logic [7:0] e_wd, e_rd, stat;
        int         nstate;
        bit         nbusy, pre_tx_ne;
        @(negedge clk);
        bus.io_write = wr; bus.io_read = rd; bus.io_addr = a; bus.io_wdata = wd;
        sx = x; sr = r; rxb = d;
        #1;
        fwd = (wr | rd) && (a == 4'd3 || a == 4'd4 || a == 4'd5);
        e_ua = 4'd2; e_uw = 0; e_ur = 0; e_wd = 8'h00;
        if (fwd) begin
            e_ua = a; e_uw = wr; e_ur = rd; e_wd = wd;
        end else if (m_state == 1) begin
            e_ua = 4'd0; e_ur = 1;
        end else if (m_state == 2) begin
            e_ua = 4'd1; e_uw = 1; e_wd = txq[0];
        end
        stat = {3'b0, m_txovf, m_rxovr, txq.size() == DEPTH, txq.size() == 0, rxq.size() != 0};
        case (a)
            4'd0:             e_rd = (rxq.size() != 0) ? rxq[0] : 8'h00;
            4'd2:             e_rd = stat;
            4'd3, 4'd4, 4'd5: e_rd = stub(e_ua, x, r, d);
            4'd6:             e_rd = {6'b0, m_rxie, m_txie};
            default:          e_rd = 8'h00;
        endcase
        e_irq = (m_rxie && rxq.size() != 0) || (m_txie && txq.size() == 0) || m_rxovr || m_txovf;
        chk("u_addr",    32'(bus.u_addr),    32'(e_ua));
        chk("u_write",   32'(bus.u_write),   32'(e_uw));
        chk("u_read",    32'(bus.u_read),    32'(e_ur));
        chk("u_wdata",   32'(bus.u_wdata),   32'(e_wd));
        chk("io_rdata",  32'(bus.io_rdata),  32'(e_rd));
        chk("interrupt", 32'(bus.interrupt), 32'(e_irq));
        if (bus.u_write === 1'b1 && bus.u_addr == 4'd1 && !fwd) txlog.push_back(bus.u_wdata);

        // advance the model by one clock
        pre_tx_ne = (txq.size() != 0);
        nstate = m_state; nbusy = m_busy; ovr_set = 0;
        if (rd && a == 4'd0 && rxq.size() != 0) void'(rxq.pop_front());
        if (!fwd) begin
            if (m_state == 0) begin
                if (r) nstate = 1;
                else if (pre_tx_ne && (!m_busy || x)) nstate = 2;
                if (x) nbusy = 0;
            end else if (m_state == 1) begin
                if (rxq.size() < DEPTH) rxq.push_back(d); else ovr_set = 1;
                nstate = 0;
            end else begin
                void'(txq.pop_front());
                nbusy = 1; nstate = 0;
            end
        end
        if (wr && a == 4'd1) begin
            if (txq.size() < DEPTH) txq.push_back(wd); else m_txovf = 1;
        end
        if (wr && a == 4'd2) begin
            if (wd[4]) m_txovf = 0;
            if (wd[3]) m_rxovr = 0;
        end
        if (ovr_set) m_rxovr = 1;
        if (wr && a == 4'd6) begin m_rxie = wd[1]; m_txie = wd[0]; end
        m_state = nstate; m_busy = nbusy;
    endtask

    // Drop reset mid-cycle and check outputs before the next clock edge
    task automatic async_reset();
        #1;
        bus.io_write = 0; bus.io_read = 0; bus.io_addr = 4'd2; bus.io_wdata = 8'h00;
        sx = 0; sr = 0; rxb = 8'h00;
        reset_n = 1'b0;
        #1;
        chk("rst_u_addr",   32'(bus.u_addr),    32'd2);
        chk("rst_u_write",  32'(bus.u_write),   32'd0);
        chk("rst_u_read",   32'(bus.u_read),    32'd0);
        chk("rst_u_wdata",  32'(bus.u_wdata),   32'd0);
        chk("rst_status",   32'(bus.io_rdata),  32'h02);
        chk("rst_irq",      32'(bus.interrupt), 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic       wr, rd;
        logic [3:0] a;
        logic [7:0] wd;
        logic       x, r;
        logic [7:0] d;
        logic [3:0] e_ua;
        logic       e_uw, e_ur;
        logic [7:0] e_wd, e_rd;
        logic       e_irq;
    } vec_t;
    vec_t tbl[16];

    initial begin
        // wr rd addr wdata x r d | u_addr u_write u_read u_wdata io_rdata irq
        tbl[0]  = '{1'b0,1'b0,4'd2,8'h00,1'b0,1'b0,8'h00, 4'd2,1'b0,1'b0,8'h00,8'h02,1'b0};
        tbl[1]  = '{1'b1,1'b0,4'd1,8'hA5,1'b0,1'b0,8'h00, 4'd2,1'b0,1'b0,8'h00,8'h00,1'b0};
        tbl[2]  = '{1'b0,1'b0,4'd2,8'h00,1'b0,1'b0,8'h00, 4'd2,1'b0,1'b0,8'h00,8'h00,1'b0};
        tbl[3]  = '{1'b0,1'b0,4'd2,8'h00,1'b0,1'b0,8'h00, 4'd1,1'b1,1'b0,8'hA5,8'h00,1'b0};
        tbl[4]  = '{1'b1,1'b0,4'd1,8'h3C,1'b0,1'b0,8'h00, 4'd2,1'b0,1'b0,8'h00,8'h00,1'b0};
        tbl[5]  = '{1'b0,1'b0,4'd2,8'h00,1'b0,1'b0,8'h00, 4'd2,1'b0,1'b0,8'h00,8'h00,1'b0};
        tbl[6]  = '{1'b0,1'b0,4'd2,8'h00,1'b1,1'b0,8'h00, 4'd2,1'b0,1'b0,8'h00,8'h00,1'b0};
        tbl[7]  = '{1'b0,1'b0,4'd2,8'h00,1'b0,1'b0,8'h00, 4'd1,1'b1,1'b0,8'h3C,8'h00,1'b0};
        tbl[8]  = '{1'b1,1'b0,4'd6,8'h03,1'b0,1'b0,8'h00, 4'd2,1'b0,1'b0,8'h00,8'h00,1'b0};
        tbl[9]  = '{1'b0,1'b0,4'd2,8'h00,1'b0,1'b1,8'h00, 4'd2,1'b0,1'b0,8'h00,8'h02,1'b1};
        tbl[10] = '{1'b0,1'b0,4'd2,8'h00,1'b0,1'b0,8'h55, 4'd0,1'b0,1'b1,8'h00,8'h02,1'b1};
        tbl[11] = '{1'b0,1'b1,4'd0,8'h00,1'b0,1'b0,8'h00, 4'd2,1'b0,1'b0,8'h00,8'h55,1'b1};
        tbl[12] = '{1'b0,1'b0,4'd2,8'h00,1'b0,1'b0,8'h00, 4'd2,1'b0,1'b0,8'h00,8'h02,1'b1};
        tbl[13] = '{1'b1,1'b0,4'd6,8'h00,1'b0,1'b0,8'h00, 4'd2,1'b0,1'b0,8'h00,8'h03,1'b1};
        tbl[14] = '{1'b0,1'b0,4'd2,8'h00,1'b0,1'b0,8'h00, 4'd2,1'b0,1'b0,8'h00,8'h02,1'b0};
        tbl[15] = '{1'b1,1'b0,4'd4,8'h07,1'b0,1'b0,8'h00, 4'd4,1'b1,1'b0,8'h07,8'hA4,1'b0};

        bus.io_write = 0; bus.io_read = 0; bus.io_addr = 4'd2; bus.io_wdata = 8'h00;
        sx = 0; sr = 0; rxb = 8'h00;
        model_reset();
        #3;
        chk("por_u_addr",  32'(bus.u_addr),    32'd2);
        chk("por_strobes", 32'({bus.u_write, bus.u_read}), 32'd0);
        chk("por_status",  32'(bus.io_rdata),  32'h02);
        chk("por_irq",     32'(bus.interrupt), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed table: TX latency, busy gating, RX path, IE, forwarding
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].wd, tbl[i].x, tbl[i].r, tbl[i].d);
            chk($sformatf("tbl%0d_u_addr", i),   32'(bus.u_addr),    32'(tbl[i].e_ua));
            chk($sformatf("tbl%0d_u_write", i),  32'(bus.u_write),   32'(tbl[i].e_uw));
            chk($sformatf("tbl%0d_u_read", i),   32'(bus.u_read),    32'(tbl[i].e_ur));
            chk($sformatf("tbl%0d_u_wdata", i),  32'(bus.u_wdata),   32'(tbl[i].e_wd));
            chk($sformatf("tbl%0d_io_rdata", i), 32'(bus.io_rdata),  32'(tbl[i].e_rd));
            chk($sformatf("tbl%0d_irq", i),      32'(bus.interrupt), 32'(tbl[i].e_irq));
        end

        // TX overflow: transmitter stays busy, 9 pushes
        for (int i = 0; i < 8; i++) step(1, 0, 4'd1, 8'(8'h10 + i), 0, 0, 8'h00);
        step(1, 0, 4'd1, 8'hEE, 0, 0, 8'h00);
        step(0, 0, 4'd2, 8'h00, 0, 0, 8'h00);
        chk("txovf_status", 32'(bus.io_rdata), 32'h14);
        chk("txovf_irq",    32'(bus.interrupt), 32'd1);
        step(1, 0, 4'd2, 8'h10, 0, 0, 8'h00);
        step(0, 0, 4'd2, 8'h00, 0, 0, 8'h00);
        chk("txovf_clear", 32'(bus.io_rdata), 32'h04);
        txlog.delete();
        for (int i = 0; i < 30; i++) step(0, 0, 4'd2, 8'h00, 1, 0, 8'h00);
        chk("tx_drain_count", 32'(txlog.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            if (i < txlog.size()) chk("tx_drain_byte", 32'(txlog[i]), 32'(8'h10 + i));

        // RX overflow: 9 bytes received without CPU pops
        for (int i = 0; i < 9; i++) begin
            step(0, 0, 4'd2, 8'h00, 0, 1, 8'h00);
            step(0, 0, 4'd2, 8'h00, 0, 0, 8'(8'h60 + i));
            chk("rx_u_read", 32'(bus.u_read), 32'd1);
        end
        step(0, 0, 4'd2, 8'h00, 0, 0, 8'h00);
        chk("rxovr_status", 32'(bus.io_rdata), 32'h0B);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 4'd0, 8'h00, 0, 0, 8'h00);
            chk("rx_pop_order", 32'(bus.io_rdata), 32'(8'h60 + i));
        end
        step(1, 0, 4'd2, 8'h08, 0, 0, 8'h00);
        step(0, 0, 4'd2, 8'h00, 0, 0, 8'h00);
        chk("rxovr_clear", 32'(bus.io_rdata), 32'h02);

        // Forwarded CPU write lands exactly on the sequencer's TX cycle
        step(1, 0, 4'd1, 8'h77, 0, 0, 8'h00);
        step(0, 0, 4'd2, 8'h00, 0, 0, 8'h00);
        step(1, 0, 4'd4, 8'h07, 0, 0, 8'h00);
        chk("fwd_u_addr",  32'(bus.u_addr),  32'd4);
        chk("fwd_u_wdata", 32'(bus.u_wdata), 32'h07);
        step(0, 0, 4'd2, 8'h00, 0, 0, 8'h00);
        chk("deferred_tx_write", 32'(bus.u_write), 32'd1);
        chk("deferred_tx_data",  32'(bus.u_wdata), 32'h77);

        // Reset during a TX cycle with bytes queued
        step(1, 0, 4'd1, 8'hA1, 0, 0, 8'h00);
        step(1, 0, 4'd1, 8'hA2, 0, 0, 8'h00);
        step(1, 0, 4'd1, 8'hA3, 0, 0, 8'h00);
        step(0, 0, 4'd2, 8'h00, 1, 0, 8'h00);
        step(0, 0, 4'd2, 8'h00, 0, 0, 8'h00);
        chk("pre_reset_tx", 32'(bus.u_write), 32'd1);
        async_reset();
        step(1, 0, 4'd1, 8'h5A, 0, 0, 8'h00);
        step(0, 0, 4'd2, 8'h00, 0, 0, 8'h00);
        step(0, 0, 4'd2, 8'h00, 0, 0, 8'h00);
        chk("post_reset_tx",   32'(bus.u_write), 32'd1);
        chk("post_reset_data", 32'(bus.u_wdata), 32'h5A);

        // Randomised traffic against the model
        for (int i = 0; i < 1500; i++) begin
            int         op;
            logic [3:0] ra;
            op = $urandom_range(0, 9);
            ra = 4'($urandom_range(0, 15));
            case (op)
                0, 1, 2: step(1, 0, 4'd1, 8'($urandom), $urandom_range(0,3) == 0,
                              $urandom_range(0,4) == 0, 8'($urandom));
                3, 4:    step(0, 1, 4'd0, 8'h00, $urandom_range(0,3) == 0,
                              $urandom_range(0,4) == 0, 8'($urandom));
                5:       step($urandom_range(0,1) == 1, 0, 4'd2, 8'($urandom),
                              $urandom_range(0,3) == 0, $urandom_range(0,4) == 0, 8'($urandom));
                6:       step(1, 0, 4'd6, 8'($urandom), $urandom_range(0,3) == 0,
                              $urandom_range(0,4) == 0, 8'($urandom));
                7: begin
                    logic w;
                    w = ($urandom_range(0,1) == 1);
                    step(w, !w, 4'($urandom_range(3,5)), 8'($urandom),
                         $urandom_range(0,3) == 0, $urandom_range(0,4) == 0, 8'($urandom));
                end
                default: step(0, $urandom_range(0,3) == 0 && ra != 4'd0, ra, 8'($urandom),
                              $urandom_range(0,3) == 0, $urandom_range(0,4) == 0, 8'($urandom));
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
